mix_columns_engine: RTL

//  Sequential AES MixColumns / InvMixColumns unit with valid/ready handshakes on both sides.

---
 rtl/mix_columns_engine.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mix_columns_engine.sv
// rtl/mix_columns_engine.sv - sequential AES MixColumns/InvMixColumns engine with valid/ready handshakes
module mix_columns_engine #(
    parameter int COLS_PER_CYCLE = 4,
    parameter int INV_EN         = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_inv,
    input  logic [0:127] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_data,
    output logic         busy
);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE % 4);
    localparam logic [1:0] LAST_CNT = 2'((4 - COLS_PER_CYCLE) % 4);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [1:0]  cnt;
    logic        mode;
    logic [31:0] work      [4];
    logic [31:0] next_work [4];

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Coefficients are at most 0x0E, so four xtime steps cover every multiplier.
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = b;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
        logic [3:0]  coef [4];
        logic [7:0]  r;
        logic [31:0] res;
        if (inv) coef = '{4'hE, 4'hB, 4'hD, 4'h9};
        else     coef = '{4'h2, 4'h3, 4'h1, 4'h1};
        res = '0;
        for (int i = 0; i < 4; i++) begin
            r = '0;
            for (int j = 0; j < 4; j++)
                r = r ^ gmul(c[31-8*j -: 8], coef[2'(j - i)]);
            res[31-8*i -: 8] = r;
        end
        return res;
    endfunction

    always_comb begin
        next_work = work;
        for (int l = 0; l < COLS_PER_CYCLE; l++)
            next_work[2'(cnt + 2'(l))] = mix_col(work[2'(cnt + 2'(l))], mode && (INV_EN != 0));
    end

    assign in_ready = (state == IDLE) || (state == DONE && out_ready);
    assign out_data = {work[0], work[1], work[2], work[3]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            mode      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            for (int c = 0; c < 4; c++) work[c] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int c = 0; c < 4; c++) work[c] <= in_data[32*c +: 32];
                        mode  <= in_inv && (INV_EN != 0);
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    work <= next_work;
                    cnt  <= cnt + STEP;
                    if (cnt == LAST_CNT) begin
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        // Output drain and next capture share one edge for full throughput.
                        if (in_valid) begin
                            for (int c = 0; c < 4; c++) work[c] <= in_data[32*c +: 32];
                            mode  <= in_inv && (INV_EN != 0);
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= BUSY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
